// File: rtl/io_out_port_pkg.sv
// io_pkg: page/offset constants and defaults shared by io_out_port.
// The blink feature is built only with IO_OUT_BLINK_EN defined.
package io_pkg;
  localparam logic [3:0] LED_PAGE_DEF  = 4'h1;
  localparam logic [3:0] HEX_PAGE_DEF  = 4'h2;
  localparam int         BLINK_DIV_DEF = 25_000_000;
  localparam int         CNT_W         = 26;

  localparam logic [1:0] OFF_DISP  = 2'd0;
  localparam logic [1:0] OFF_BLANK = 2'd1;
  localparam logic [1:0] OFF_BLINK = 2'd2;

  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_LED,
    DEC_DISP,
    DEC_BLANK,
    DEC_BLINK
  } dec_e;
endpackage

// File: rtl/io_out_port_if.sv
// io_out_port_if: processor store bus with a write acknowledge.
// The master drives address/data/strobe; the slave returns ACK.
interface io_out_port_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic        ACK;

  modport master (
    output ADDR,
    output DOUT,
    output W,
    input  ACK
  );

  modport slave (
    input  ADDR,
    input  DOUT,
    input  W,
    output ACK
  );
endinterface

// File: rtl/io_out_port_blink_prescaler.sv
// blink_prescaler: counts 0..DIV-1 and toggles phase on every wrap.
// Present only when IO_OUT_BLINK_EN is defined.
`ifdef IO_OUT_BLINK_EN
module blink_prescaler
  import io_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic [CNT_W-1:0] DIV,
  output logic             phase
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic             w_wrap;

  assign w_wrap = (r_cnt == DIV - 1'b1);
  assign phase  = r_phase;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/io_out_port.sv
// io_out_port: memory-mapped LED and hex-display output registers.
// Define IO_OUT_BLINK_EN to add per-digit blinking.
module io_out_port
  import io_pkg::*;
#(
  parameter logic [3:0] LED_PAGE  = LED_PAGE_DEF,
  parameter logic [3:0] HEX_PAGE  = HEX_PAGE_DEF,
  parameter int         BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic          Clock,
  input  logic          Reset,
  io_out_port_if.slave  bus,
  output logic [9:0]    LEDR,
  output logic [15:0]   DISP,
  output logic [3:0]    BLANK
);
  logic [9:0]  r_ledr;
  logic [15:0] r_disp;
  logic [3:0]  r_blank;
  logic [3:0]  r_blank_mask;
  logic        r_ack;

  logic [3:0]  w_page;
  logic [1:0]  w_off;
  logic        w_led;
  logic        w_hex;
  logic [3:0]  w_blink_term;
  dec_e        w_dec;
  logic        w_unused;

  assign w_page = bus.ADDR[15:12];
  assign w_off  = bus.ADDR[1:0];
  // LED decode wins when both pages are configured equal
  assign w_led  = (w_page == LED_PAGE);
  assign w_hex  = (w_page == HEX_PAGE) && !w_led;

  assign w_unused = ^{bus.ADDR[11:2], 26'(BLINK_DIV)};

  always_comb begin
    w_dec = DEC_NONE;
    if (bus.W) begin
      unique case (1'b1)
        w_led:                         w_dec = DEC_LED;
        (w_hex && w_off == OFF_DISP):  w_dec = DEC_DISP;
        (w_hex && w_off == OFF_BLANK): w_dec = DEC_BLANK;
`ifdef IO_OUT_BLINK_EN
        (w_hex && w_off == OFF_BLINK): w_dec = DEC_BLINK;
`endif
        default:                       w_dec = DEC_NONE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ledr       <= '0;
      r_disp       <= '0;
      r_blank_mask <= '0;
      r_blank      <= '0;
      r_ack        <= 1'b0;
    end else begin
      r_ack   <= (w_dec != DEC_NONE);
      r_blank <= r_blank_mask | w_blink_term;
      if (w_dec == DEC_LED)   r_ledr       <= bus.DOUT[9:0];
      if (w_dec == DEC_DISP)  r_disp       <= bus.DOUT;
      if (w_dec == DEC_BLANK) r_blank_mask <= bus.DOUT[3:0];
    end
  end

`ifdef IO_OUT_BLINK_EN
  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(BLINK_DIV);

  logic [3:0] r_blink_mask;
  logic       w_phase;

  blink_prescaler u_presc (
    .Clock (Clock),
    .Reset (Reset),
    .DIV   (DIV_V),
    .phase (w_phase)
  );

  always_ff @(posedge Clock) begin
    if (Reset)                   r_blink_mask <= '0;
    else if (w_dec == DEC_BLINK) r_blink_mask <= bus.DOUT[3:0];
  end

  assign w_blink_term = r_blink_mask & {4{w_phase}};
`else
  assign w_blink_term = '0;
`endif

  assign bus.ACK = r_ack;
  assign LEDR    = r_ledr;
  assign DISP    = r_disp;
  assign BLANK   = r_blank;
endmodule
